// File: rtl/apb_seq_pkg.sv
// Shared types and default widths for the APB command sequencer.
package apb_seq_pkg;

  localparam int unsigned DefAddrW = 32;
  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefDepth = 4;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } seq_state_e;

  typedef struct packed {
    logic                write;
    logic [DefAddrW-1:0] addr;
    logic [DefDataW-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Depth-entry command FIFO with occupancy count; push is ignored when full,
// pop is ignored when empty.
module apb_cmd_fifo
  import apb_seq_pkg::*;
#(
  parameter int unsigned Depth = DefDepth,
  parameter type entry_t = apb_cmd_t,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned LvlW = $clog2(Depth) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  entry_t          wdata_i,
  input  logic            pop_i,
  output entry_t          rdata_o,
  output logic [LvlW-1:0] level_o
);

  entry_t          mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [LvlW-1:0] level_q;
  logic            push_ok, pop_ok;

  assign push_ok = push_i && (level_q < LvlW'(Depth));
  assign pop_ok  = pop_i && (level_q != '0);

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PtrW'(1);
      if (pop_ok)  rptr_q <= rptr_q + PtrW'(1);
      level_q <= level_q + LvlW'(push_ok) - LvlW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/apb_cmd_sequencer.sv
// Host command front-end for APB_master: buffers commands, issues them one at
// a time and returns a response per completed transfer.
module apb_cmd_sequencer
  import apb_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [DATA_W-1:0]        cmd_wdata,
  output logic                     PWRITE_MASTER,
  output logic [ADDR_W-1:0]        PADDR_MASTER,
  output logic [DATA_W-1:0]        PWDATA_MASTER,
  output logic                     m_req,
  input  logic                     PENABLE,
  input  logic                     PREADY,
  input  logic [DATA_W-1:0]        PRDATA_MASTER,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_write,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned LvlW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  seq_state_e        state_q, state_d;
  cmd_t              push_cmd, head_cmd, cmd_q, cmd_d;
  logic              pop, done;
  logic              m_req_q, m_req_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  assign cmd_ready = (level < LvlW'(DEPTH));
  assign push_cmd  = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  assign done      = m_req_q && PENABLE && PREADY;

  apb_cmd_fifo #(
    .Depth   (DEPTH),
    .entry_t (cmd_t)
  ) u_fifo (
    .clk_i   (PCLK),
    .rst_ni  (PRESETn),
    .push_i  (cmd_valid && cmd_ready),
    .wdata_i (push_cmd),
    .pop_i   (pop),
    .rdata_o (head_cmd),
    .level_o (level)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (level != '0) state_d = StBusy;
      StBusy:  if (done) state_d = StResp;
      StResp:  if (rsp_valid_q && rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pop         = 1'b0;
    cmd_d       = cmd_q;
    m_req_d     = m_req_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      StIdle: begin
        if (level != '0) begin
          pop     = 1'b1;
          cmd_d   = head_cmd;
          m_req_d = 1'b1;
        end
      end
      StBusy: begin
        if (done) begin
          m_req_d     = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = cmd_q.write;
          rsp_rdata_d = cmd_q.write ? '0 : PRDATA_MASTER;
        end
      end
      StResp: begin
        if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cmd_q       <= '0;
      m_req_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      cmd_q       <= cmd_d;
      m_req_q     <= m_req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign PWRITE_MASTER = cmd_q.write;
  assign PADDR_MASTER  = cmd_q.addr;
  assign PWDATA_MASTER = cmd_q.wdata;
  assign m_req         = m_req_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Scoreboard bench: a small APB master/slave model plus queues of expected
// transfers and responses filled at push time.
module tb_apb_cmd_sequencer;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        PWRITE_MASTER;
  logic [31:0] PADDR_MASTER;
  logic [31:0] PWDATA_MASTER;
  logic        m_req;
  logic        PENABLE;
  logic        PREADY;
  logic [31:0] PRDATA_MASTER;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [2:0]  level;

  typedef struct packed {logic write; logic [31:0] addr; logic [31:0] data;} xfer_t;
  typedef struct packed {logic write; logic [31:0] rdata;} rsp_t;

  xfer_t       apb_q[$];
  rsp_t        rsp_q[$];
  xfer_t       apb_exp;
  rsp_t        rsp_exp;
  logic [31:0] ref_mem [4] = '{default: 32'h0};
  logic [31:0] slv_mem [4];
  logic        psel, penable_q, stall = 1'b0;
  int          errors = 0, checks = 0, rsp_cnt = 0;

  always #5 PCLK = ~PCLK;

  apb_cmd_sequencer #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
    .PCLK          (PCLK),
    .PRESETn       (PRESETn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .PWRITE_MASTER (PWRITE_MASTER),
    .PADDR_MASTER  (PADDR_MASTER),
    .PWDATA_MASTER (PWDATA_MASTER),
    .m_req         (m_req),
    .PENABLE       (PENABLE),
    .PREADY        (PREADY),
    .PRDATA_MASTER (PRDATA_MASTER),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_write     (rsp_write),
    .rsp_rdata     (rsp_rdata),
    .level         (level)
  );

  // APB master + 4-word slave model: setup phase, then access until PREADY.
  assign PENABLE       = penable_q;
  assign PREADY        = !stall;
  assign PRDATA_MASTER = slv_mem[PADDR_MASTER[3:2]];

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      psel      <= 1'b0;
      penable_q <= 1'b0;
      for (int i = 0; i < 4; i++) slv_mem[i] <= 32'h0;
    end else if (!psel) begin
      if (m_req) psel <= 1'b1;
    end else if (!penable_q) begin
      penable_q <= 1'b1;
    end else if (PREADY) begin
      psel      <= 1'b0;
      penable_q <= 1'b0;
      if (PWRITE_MASTER) slv_mem[PADDR_MASTER[3:2]] <= PWDATA_MASTER;
    end
  end

  always @(negedge PCLK) begin
    if (PRESETn && m_req && PENABLE && PREADY) begin
      checks++;
      if (apb_q.size() == 0) begin
        errors++;
        $display("FAIL apb_unexpected: got w=%0b addr=%h, required none", PWRITE_MASTER,
                 PADDR_MASTER);
      end else begin
        apb_exp = apb_q.pop_front();
        if (PWRITE_MASTER !== apb_exp.write || PADDR_MASTER !== apb_exp.addr ||
            (apb_exp.write && PWDATA_MASTER !== apb_exp.data)) begin
          errors++;
          $display("FAIL apb_order: got w=%0b a=%h d=%h, required w=%0b a=%h d=%h",
                   PWRITE_MASTER, PADDR_MASTER, PWDATA_MASTER, apb_exp.write, apb_exp.addr,
                   apb_exp.data);
        end
      end
    end
  end

  always @(negedge PCLK) begin
    if (PRESETn && rsp_valid && rsp_ready) begin
      checks++;
      rsp_cnt++;
      if (rsp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got w=%0b rdata=%h, required none", rsp_write, rsp_rdata);
      end else begin
        rsp_exp = rsp_q.pop_front();
        if (rsp_write !== rsp_exp.write || rsp_rdata !== rsp_exp.rdata) begin
          errors++;
          $display("FAIL rsp_data: got w=%0b rdata=%h, required w=%0b rdata=%h", rsp_write,
                   rsp_rdata, rsp_exp.write, rsp_exp.rdata);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
    bit ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge PCLK);
      if (cmd_ready) begin
        ok = 1'b1;
        apb_q.push_back('{write: w, addr: a, data: d});
        if (w) ref_mem[a[3:2]] = d;
        rsp_q.push_back('{write: w, rdata: (w ? 32'h0 : ref_mem[a[3:2]])});
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_timeout: cmd_ready=%0b, required 1 within 200 cycles", cmd_ready);
    end
    @(posedge PCLK);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    for (int i = 0; i < 300 && rsp_cnt < target; i++) @(negedge PCLK);
    @(posedge PCLK);
    #1;
    checks++;
    if (rsp_cnt != target) begin
      errors++;
      $display("FAIL rsp_count: got %0d responses, required %0d", rsp_cnt, target);
    end
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    checks++;
    if ({cmd_ready, m_req, rsp_valid, rsp_write, PWRITE_MASTER, level} !== 8'b1000_0000 ||
        PADDR_MASTER !== 32'h0 || PWDATA_MASTER !== 32'h0 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: got rdy=%0b mreq=%0b rv=%0b lvl=%0d addr=%h, required 1 0 0 0 0",
               cmd_ready, m_req, rsp_valid, level, PADDR_MASTER);
    end
    PRESETn = 1'b1;
    @(posedge PCLK);
    #1;
  endtask

  task automatic test_single_write();
    bit seen = 1'b0;
    rsp_ready = 1'b1;
    push(1'b1, 32'h0, 32'h2);
    checks++;
    if (m_req !== 1'b0 || level !== 3'd1) begin
      errors++;
      $display("FAIL latency_push: got m_req=%0b level=%0d, required 0 1", m_req, level);
    end
    @(posedge PCLK);
    #1;
    checks++;
    if (m_req !== 1'b1 || level !== 3'd0 || PWRITE_MASTER !== 1'b1 || PADDR_MASTER !== 32'h0) begin
      errors++;
      $display("FAIL latency_issue: got m_req=%0b level=%0d w=%0b, required 1 0 1", m_req, level,
               PWRITE_MASTER);
    end
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge PCLK);
      seen = m_req && PENABLE && PREADY;
    end
    @(posedge PCLK);
    #1;
    checks++;
    if (!seen || rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL write_rsp: got done=%0b rv=%0b rw=%0b rd=%h, required 1 1 1 0", seen,
               rsp_valid, rsp_write, rsp_rdata);
    end
    wait_rsp(1);
    push(1'b0, 32'h0, 32'h0);
    wait_rsp(2);
  endtask

  task automatic test_queued_writes();
    logic [31:0] wd [4] = '{32'h2, 32'h27122023, 32'h81EBE7A8, 32'h85A3AEE0};
    int base = rsp_cnt;
    stall = 1'b1;
    push(1'b1, 32'h0, 32'h2);  // occupies the FSM so the next four fill the FIFO
    for (int i = 0; i < 4; i++) push(1'b1, 32'(i * 4), wd[i]);
    checks++;
    if (level !== 3'd4 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL fifo_full: got level=%0d cmd_ready=%0b, required 4 0", level, cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h10;
    cmd_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      checks++;
      if (cmd_ready !== 1'b0 || level !== 3'd4) begin
        errors++;
        $display("FAIL fifo_no_push: got cmd_ready=%0b level=%0d, required 0 4", cmd_ready, level);
      end
    end
    @(posedge PCLK);
    #1;
    cmd_valid = 1'b0;
    stall = 1'b0;
    wait_rsp(base + 5);
  endtask

  task automatic test_queued_reads();
    int base = rsp_cnt;
    for (int i = 0; i < 4; i++) push(1'b0, 32'(i * 4), 32'h0);
    wait_rsp(base + 4);
  endtask

  task automatic test_wait_states();
    bit seen = 1'b0;
    int base = rsp_cnt;
    stall = 1'b1;
    push(1'b0, 32'h4, 32'h0);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge PCLK);
      seen = m_req && PENABLE;
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge PCLK);
      #1;
      checks++;
      if (!seen || m_req !== 1'b1 || PENABLE !== 1'b1 || PADDR_MASTER !== 32'h4 ||
          rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL wait_hold: got m_req=%0b pen=%0b addr=%h rv=%0b, required 1 1 4 0", m_req,
                 PENABLE, PADDR_MASTER, rsp_valid);
      end
    end
    stall = 1'b0;
    wait_rsp(base + 1);
    repeat (6) @(posedge PCLK);
    #1;
    checks++;
    if (rsp_cnt != base + 1) begin
      errors++;
      $display("FAIL wait_single_rsp: got %0d responses, required %0d", rsp_cnt - base, 1);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    int base = rsp_cnt;
    rsp_ready = 1'b0;
    push(1'b0, 32'h8, 32'h0);
    for (int i = 0; i < 30 && !rsp_valid; i++) @(negedge PCLK);
    @(posedge PCLK);
    #1;
    held = rsp_rdata;
    checks++;
    if (rsp_valid !== 1'b1 || held !== 32'h81EBE7A8) begin
      errors++;
      $display("FAIL bp_rsp: got rv=%0b rdata=%h, required 1 81ebe7a8", rsp_valid, held);
    end
    for (int i = 0; i < 5; i++) begin
      if (i < 4) push(1'b0, 32'(i * 4), 32'h0);
      else begin
        @(posedge PCLK);
        #1;
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== held || m_req !== 1'b0 ||
          level !== 3'(i < 4 ? i + 1 : 4)) begin
        errors++;
        $display("FAIL bp_hold: got rv=%0b rd=%h m_req=%0b level=%0d, required 1 %h 0 %0d",
                 rsp_valid, rsp_rdata, m_req, level, held, (i < 4 ? i + 1 : 4));
      end
    end
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: got cmd_ready=%0b, required 0", cmd_ready);
    end
    rsp_ready = 1'b1;
    wait_rsp(base + 5);
    checks++;
    if (apb_q.size() != 0 || rsp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending, required 0/0", apb_q.size(), rsp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int base;
    stall = 1'b1;
    push(1'b0, 32'h0, 32'h0);
    push(1'b0, 32'h4, 32'h0);
    push(1'b0, 32'h8, 32'h0);
    checks++;
    if (m_req !== 1'b1 || level !== 3'd2) begin
      errors++;
      $display("FAIL rst_setup: got m_req=%0b level=%0d, required 1 2", m_req, level);
    end
    #2;
    PRESETn = 1'b0;
    #1;
    checks++;
    if (m_req !== 1'b0 || rsp_valid !== 1'b0 || level !== 3'd0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: got m_req=%0b rv=%0b level=%0d rdy=%0b, required 0 0 0 1", m_req,
               rsp_valid, level, cmd_ready);
    end
    apb_q.delete();
    rsp_q.delete();
    base  = rsp_cnt;
    stall = 1'b0;
    @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    repeat (20) @(posedge PCLK);
    #1;
    checks++;
    if (rsp_cnt != base || m_req !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL rst_after: got rsp=%0d m_req=%0b level=%0d, required 0 0 0", rsp_cnt - base,
               m_req, level);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_queued_writes();
    test_queued_reads();
    test_wait_states();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
